// File: rtl/bcd_to_binary.sv
// Packed-BCD to binary converter (reverse double-dabble), one bit per SHIFT/ADJUST pair.
// Start/done handshake; requests containing a digit above 9 finish immediately with err_op set.
module bcd_to_binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk_1mhz,
    input  logic                  reset_n_ip,
    input  logic                  start_ip,
    input  logic [4*DIGITS-1:0]   bcd_data_ip,
    output logic                  busy_op,
    output logic                  done_op,
    output logic [BIN_W-1:0]      bin_data_op,
    output logic                  err_op
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [IT_W-1:0] IT_MAX = IT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [BCD_W-1:0]  bcd_sr_q,   bcd_sr_d;
    logic [BIN_W-1:0]  bin_sr_q,   bin_sr_d;
    logic [IT_W-1:0]   it_q,       it_d;
    logic [BIN_W-1:0]  bin_data_q, bin_data_d;
    logic              err_q,      err_d;

    logic [DIGITS-1:0] digit_bad;
    logic [BCD_W-1:0]  bcd_adj;

    // Per-digit legality check on the input and -3 correction on the shift register.
    // A digit >= 8 after a right shift was >= 16 before halving, so it never underflows.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digit_bad[gi] = bcd_data_ip[4*gi+3] & (bcd_data_ip[4*gi+2] | bcd_data_ip[4*gi+1]);
        assign bcd_adj[4*gi +: 4] = bcd_sr_q[4*gi+3] ? (bcd_sr_q[4*gi +: 4] - 4'd3)
                                                      : bcd_sr_q[4*gi +: 4];
    end

    always_comb begin
        state_d    = state_q;
        bcd_sr_d   = bcd_sr_q;
        bin_sr_d   = bin_sr_q;
        it_d       = it_q;
        bin_data_d = bin_data_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (start_ip) begin
                    if (|digit_bad) begin
                        bin_data_d = '0;
                        err_d      = 1'b1;
                        state_d    = DONE;
                    end else begin
                        bcd_sr_d = bcd_data_ip;
                        bin_sr_d = '0;
                        it_d     = '0;
                        state_d  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                {bcd_sr_d, bin_sr_d} = {1'b0, bcd_sr_q, bin_sr_q[BIN_W-1:1]};
                state_d              = ADJUST;
            end
            ADJUST: begin
                bcd_sr_d = bcd_adj;
                if (it_q == IT_MAX) begin
                    bin_data_d = bin_sr_q;
                    err_d      = 1'b0;
                    state_d    = DONE;
                end else begin
                    it_d    = it_q + IT_W'(1);
                    state_d = SHIFT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1mhz or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            state_q    <= IDLE;
            bcd_sr_q   <= '0;
            bin_sr_q   <= '0;
            it_q       <= '0;
            bin_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_sr_q   <= bcd_sr_d;
            bin_sr_q   <= bin_sr_d;
            it_q       <= it_d;
            bin_data_q <= bin_data_d;
            err_q      <= err_d;
        end
    end

    // Status decoded straight from state so an async reset clears it immediately.
    assign busy_op     = (state_q != IDLE);
    assign done_op     = (state_q == DONE);
    assign bin_data_op = bin_data_q;
    assign err_op      = err_q;

endmodule
